shreg_seq_ctrl: RTL and testbench

Sequencer for the N-bit universal shift register (modes hold / shift-down / shift-up / parallel load). It accepts one command at a time over a start/busy/done handshake. Each command is a parallel load, or a multi-cycle shift of 0..N positions with a selectable fill policy. The block drives the register's A1:A0 mode select, DL/DR serial inputs and parallel D bus, and observes its Q outputs. It sits beside the register, sharing its clock and reset, and is the only master of the register's control pins.

---
 rtl/shreg_seq_ctrl_pkg.sv | 42 ++++
 rtl/shreg_seq_ctrl_if.sv | 25 ++
 rtl/shreg_univ.sv | 34 +++
 rtl/shreg_seq_ctrl.sv | 107 ++++++++++
 tb/tb_shreg_seq_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/shreg_seq_ctrl_pkg.sv
// Shared types and constants for the universal shift register sequencer.
// Mode encodings match the register's {A1,A0} select pins.
package shreg_ctrl_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        CMD_LOAD       = 2'b00,
        CMD_SHIFT_DOWN = 2'b01,
        CMD_SHIFT_UP   = 2'b10,
        CMD_RSVD       = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        FILL_ZERO   = 2'b00,
        FILL_ONE    = 2'b01,
        FILL_ROTATE = 2'b10,
        FILL_SIGN   = 2'b11
    } fill_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // rot_bit is the bit leaving the far end; sgn_bit is the bit at the
    // entry end, which is replicated for sign fill.
    function automatic logic fill_bit(fill_t f, logic rot_bit, logic sgn_bit);
        case (f)
            FILL_ZERO:   fill_bit = 1'b0;
            FILL_ONE:    fill_bit = 1'b1;
            FILL_ROTATE: fill_bit = rot_bit;
            default:     fill_bit = sgn_bit;
        endcase
    endfunction

endpackage

// File: rtl/shreg_seq_ctrl_if.sv
// Command handshake between a requester and the shift register sequencer.
interface shreg_seq_ctrl_if
    import shreg_ctrl_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
);
    logic          start;
    cmd_t          cmd;
    fill_t         fill;
    logic [CW-1:0] amount;
    logic [N-1:0]  data_in;
    logic          busy;
    logic          done;

    modport master (
        output start, cmd, fill, amount, data_in,
        input  busy, done
    );

    modport slave (
        input  start, cmd, fill, amount, data_in,
        output busy, done
    );
endinterface

// File: rtl/shreg_univ.sv
// N-bit universal shift register: hold / shift-down / shift-up / parallel load.
module shreg_univ
    import shreg_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [1:0]   mode,
    input  logic         dl,
    input  logic         dr,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        case (mode)
            MODE_DOWN: q_d = {dr, q_q[N-1:1]};
            MODE_UP:   q_d = {q_q[N-2:0], dl};
            MODE_LOAD: q_d = d;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/shreg_seq_ctrl.sv
// Sequencer driving a universal shift register: one load or multi-cycle
// shift per accepted command, with a one-cycle done pulse at the end.
module shreg_seq_ctrl
    import shreg_ctrl_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    shreg_seq_ctrl_if.slave       cif,
    input  logic [N-1:0]          q,
    output logic [1:0]            mode,
    output logic                  dl,
    output logic                  dr,
    output logic [N-1:0]          d
);
    state_t        state_q, state_d;
    cmd_t          cmd_q,   cmd_d;
    fill_t         fill_q,  fill_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [N-1:0]  data_q,  data_d;
    logic [1:0]    mode_q,  mode_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic [CW-1:0] amt_clamp;

    assign amt_clamp = (cif.amount > CW'(N)) ? CW'(N) : cif.amount;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (cif.start) begin
                    cmd_d  = cif.cmd;
                    fill_d = cif.fill;
                    data_d = cif.data_in;
                    cnt_d  = (cif.cmd == CMD_RSVD) ? '0 : amt_clamp;
                    if (cif.cmd == CMD_LOAD)
                        state_d = ST_LOAD;
                    else if (cif.cmd == CMD_RSVD || amt_clamp == '0)
                        state_d = ST_DONE;
                    else
                        state_d = ST_SHIFT;
                end
            end
            ST_LOAD: state_d = ST_DONE;
            ST_SHIFT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        mode_d = MODE_HOLD;
        busy_d = 1'b1;
        done_d = 1'b0;
        case (state_d)
            ST_IDLE:  busy_d = 1'b0;
            ST_LOAD:  mode_d = MODE_LOAD;
            ST_SHIFT: mode_d = (cmd_d == CMD_SHIFT_DOWN) ? MODE_DOWN : MODE_UP;
            default:  done_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_LOAD;
            fill_q  <= FILL_ZERO;
            cnt_q   <= '0;
            data_q  <= '0;
            mode_q  <= MODE_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Fill follows the live q so every step sees the freshly shifted value.
    always_comb begin
        dl = 1'b0;
        dr = 1'b0;
        if (state_q == ST_SHIFT) begin
            if (cmd_q == CMD_SHIFT_DOWN) dr = fill_bit(fill_q, q[0], q[N-1]);
            else                         dl = fill_bit(fill_q, q[N-1], q[0]);
        end
    end

    assign mode     = mode_q;
    assign d        = data_q;
    assign cif.busy = busy_q;
    assign cif.done = done_q;
endmodule

// File: tb/tb_shreg_seq_ctrl.sv
// Scoreboard bench: sequencer paired with an 8-bit universal shift register.
module tb_shreg_seq_ctrl;
    import shreg_ctrl_pkg::*;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    shreg_seq_ctrl_if #(.N(N), .CW(CW)) cif();

    logic [N-1:0] q, d;
    logic [1:0]   mode;
    logic         dl, dr;

    shreg_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clock(clock), .reset(reset), .cif(cif),
        .q(q), .mode(mode), .dl(dl), .dr(dr), .d(d)
    );

    shreg_univ #(.N(N)) sr (
        .clock(clock), .reset(reset), .mode(mode),
        .dl(dl), .dr(dr), .d(d), .q(q)
    );

    typedef struct {
        logic [7:0] q;
        int         busy_len;
        int         n_down;
        int         n_up;
        int         n_load;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_q = 8'h00;
    int         cyc = 0;
    int         done_cycs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: apply the command to an abstract 8-bit value, one position at a time.
    task automatic model(input int c, input int f, input int amt, input logic [7:0] data, output exp_t e);
        int  k;
        logic b;
        k = (amt > N) ? N : amt;
        e.n_down = 0; e.n_up = 0; e.n_load = 0;
        if (c == 0) begin
            model_q = data;
            e.busy_len = 2;
            e.n_load = 1;
        end else if (c == 3 || k == 0) begin
            e.busy_len = 1;
        end else begin
            for (int i = 0; i < k; i++) begin
                if (c == 1) begin
                    b = (f == 0) ? 1'b0 : (f == 1) ? 1'b1 : (f == 2) ? model_q[0] : model_q[7];
                    model_q = {b, model_q[7:1]};
                end else begin
                    b = (f == 0) ? 1'b0 : (f == 1) ? 1'b1 : (f == 2) ? model_q[7] : model_q[0];
                    model_q = {model_q[6:0], b};
                end
            end
            e.busy_len = k + 1;
            if (c == 1) e.n_down = k; else e.n_up = k;
        end
        e.q = model_q;
    endtask

    // Monitor: counts activity per command and compares at each done pulse.
    initial begin
        int bl = 0, nd = 0, nu = 0, nl = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                bl = 0; nd = 0; nu = 0; nl = 0;
            end else begin
                if (cif.busy === 1'b1) bl++;
                if (mode == MODE_DOWN) nd++;
                if (mode == MODE_UP)   nu++;
                if (mode == MODE_LOAD) nl++;
                if (cif.done === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("done_unexpected", 32'(cif.done), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("q_at_done", 32'(q), 32'(e.q));
                        chk("busy_len", 32'(bl), 32'(e.busy_len));
                        chk("mode_down_cycles", 32'(nd), 32'(e.n_down));
                        chk("mode_up_cycles", 32'(nu), 32'(e.n_up));
                        chk("mode_load_cycles", 32'(nl), 32'(e.n_load));
                    end
                    done_cycs.push_back(cyc);
                    bl = 0; nd = 0; nu = 0; nl = 0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic issue(input int c, input int f, input int amt, input logic [7:0] data, input bit hold);
        int   guard = 0;
        exp_t e;
        while (cif.busy === 1'b1 && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 200) chk("busy_timeout", 32'(guard), 32'd0);
        cif.cmd     = cmd_t'(c[1:0]);
        cif.fill    = fill_t'(f[1:0]);
        cif.amount  = amt[CW-1:0];
        cif.data_in = data;
        cif.start   = 1'b1;
        @(posedge clock); #1;
        model(c, f, amt, data, e);
        sb.push_back(e);
        if (!hold) cif.start = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((sb.size() != 0 || cif.busy === 1'b1) && guard < 300) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 300) chk("idle_timeout", 32'(guard), 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, 32'(cif.busy), 32'd0);
        chk({tag, "_done"}, 32'(cif.done), 32'd0);
        chk({tag, "_mode"}, 32'(mode), 32'(MODE_HOLD));
        chk({tag, "_d"},    32'(d), 32'd0);
        chk({tag, "_q"},    32'(q), 32'd0);
    endtask

    initial begin
        int n0;
        cif.start = 1'b0; cif.cmd = CMD_LOAD; cif.fill = FILL_ZERO;
        cif.amount = '0; cif.data_in = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_checks("reset");
        reset = 1'b1;
        @(posedge clock); #1;

        // Directed cases
        issue(0, 0, 0, 8'hA5, 0); wait_idle();
        issue(0, 0, 0, 8'h81, 0); issue(1, 0, 3, 8'h00, 0); wait_idle();
        issue(0, 0, 0, 8'h81, 0); issue(2, 2, 1, 8'h00, 0); wait_idle();
        issue(0, 0, 0, 8'h90, 0); issue(1, 3, 2, 8'h00, 0); wait_idle();
        issue(0, 0, 0, 8'h00, 0); issue(2, 1, 12, 8'h00, 0); wait_idle();
        issue(2, 1, 0, 8'h00, 0); wait_idle();
        chk("q_after_zero_amount", 32'(q), 32'hFF);

        // start pulsed while busy must not queue a second command
        issue(1, 0, 5, 8'h00, 0);
        cif.cmd = CMD_LOAD; cif.data_in = 8'h55; cif.start = 1'b1;
        @(posedge clock); #1;
        cif.start = 1'b0;
        wait_idle();
        chk("q_after_ignored_start", 32'(q), 32'h07);

        // Reset mid-shift: abort, clear, and no done
        issue(0, 0, 0, 8'hFF, 0); wait_idle();
        issue(1, 0, 5, 8'h00, 0);
        cif.cmd = CMD_LOAD; cif.data_in = 8'h55; cif.start = 1'b1;
        @(posedge clock); #1;
        cif.start = 1'b0;
        reset = 1'b0;
        sb.delete();
        model_q = 8'h00;
        @(posedge clock); #1;
        reset_checks("abort");
        reset = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        chk("abort_q_stays", 32'(q), 32'd0);

        // Back-to-back with start held high
        n0 = done_cycs.size();
        issue(0, 0, 0, 8'h3C, 1); issue(1, 0, 1, 8'h00, 1);
        issue(0, 0, 0, 8'h3C, 1); issue(1, 0, 1, 8'h00, 0);
        wait_idle();
        chk("b2b_q", 32'(q), 32'h1E);
        for (int i = n0 + 1; i < done_cycs.size(); i++)
            chk("b2b_done_spacing", 32'(done_cycs[i] - done_cycs[i-1]), 32'd3);

        // Randomized commands
        for (int i = 0; i < 60; i++) begin
            issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), 8'($urandom),
                  (i != 59) && ($urandom_range(0, 1) == 1));
        end
        wait_idle();
        chk("final_q", 32'(q), 32'(model_q));
        repeat (4) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
